acia_arbiter: RTL and testbench

Bus-master controller that owns the register port of the ACIA and shares its transmitter among `N_REQ` byte-stream requesters while draining its receiver into a one-entry output holding register. After reset it performs the ACIA master-reset and control-register programming sequence. It then runs a fixed poll/read/write state machine that paces every transfer off the ACIA status byte. It replaces CPU-driven access when the serial port serves hardware clients.

---
 rtl/acia_arb_pkg.sv | 25 ++
 rtl/acia_rr_arbiter.sv | 46 ++++
 rtl/acia_arbiter.sv | 158 +++++++++++++++
 tb/tb_acia_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acia_arb_pkg.sv
// Shared state encoding, register-select values and status bit positions for acia_arbiter.
// Optional build macro ACIA_ARB_IRQ_EN is consumed by acia_arbiter, not by this package.
package acia_arb_pkg;

  typedef enum logic [2:0] {
    INIT_RST,
    INIT_CFG,
    IDLE,
    RD_STAT,
    CHK_STAT,
    RD_DATA,
    CAP_DATA,
    WR_DATA
  } acia_state_e;

  localparam logic       RS_CTRL       = 1'b0;
  localparam logic       RS_DATA       = 1'b1;
  localparam logic [7:0] CTRL_MRST     = 8'h03;
  localparam logic [7:0] CTRL_IRQ_BITS = 8'hA0;

  localparam int ST_RXF = 0;
  localparam int ST_TXE = 1;
  localparam int ST_ERR = 4;

endpackage

// File: rtl/acia_rr_arbiter.sv
// Round-robin selector: grants the first valid requester at or after the pointer;
// the pointer advances past the grant whenever i_update is strobed.
module acia_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] i_valid,
  input  logic             i_update,
  output logic [IDX_W-1:0] o_grant,
  output logic             o_any
);

  logic [IDX_W-1:0] r_ptr;
  logic [N_REQ-1:0] w_at_or_above;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_mask
      assign w_at_or_above[gi] = i_valid[gi] && (IDX_W'(gi) >= r_ptr);
    end
  endgenerate

  // Lowest valid index overall is the wrap-around fallback; a valid index at or
  // above the pointer overrides it.
  always_comb begin
    o_grant = '0;
    o_any   = |i_valid;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_valid[i]) o_grant = IDX_W'(i);
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_at_or_above[i]) o_grant = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_update) begin
      r_ptr <= (o_grant == IDX_W'(N_REQ - 1)) ? '0 : o_grant + 1'b1;
    end
  end

endmodule

// File: rtl/acia_arbiter.sv
// ACIA bus master: resets/programs the ACIA, then polls status to drain RX into a
// one-entry holding register and serve N_REQ TX requesters. Macro ACIA_ARB_IRQ_EN gates polling on acia_irq.
module acia_arbiter
  import acia_arb_pkg::*;
#(
  parameter int         N_REQ     = 4,
  parameter logic [7:0] CTRL_INIT = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  output logic               acia_cs,
  output logic               acia_we,
  output logic               acia_rs,
  output logic [7:0]         acia_din,
  input  logic [7:0]         acia_dout,
  input  logic               acia_irq,
  input  logic [N_REQ-1:0]   tx_valid,
  input  logic [8*N_REQ-1:0] tx_data,
  output logic [N_REQ-1:0]   tx_ready,
  output logic               rx_valid,
  output logic [7:0]         rx_data,
  output logic               rx_err,
  input  logic               rx_ready
);

  localparam int IDX_W = $clog2(N_REQ);

  acia_state_e      r_state;
  logic             r_run;
  logic             r_cs, r_we, r_rs;
  logic [7:0]       r_din;
  logic             r_rx_valid, r_rx_err, r_err_lat;
  logic [7:0]       r_rx_data;

  logic [IDX_W-1:0] w_grant;
  logic             w_any;
  logic             w_in_chk, w_pop, w_rx_take, w_tx_fire, w_irq_go;
  logic [7:0]       w_cfg_byte, w_tx_byte;
  logic [7:0]       w_tx_bytes [N_REQ];

`ifdef ACIA_ARB_IRQ_EN
  assign w_cfg_byte = CTRL_INIT | CTRL_IRQ_BITS;
  assign w_irq_go   = acia_irq;
`else
  logic w_unused_irq;
  assign w_cfg_byte   = CTRL_INIT;
  assign w_irq_go     = 1'b1;
  assign w_unused_irq = acia_irq;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign w_tx_bytes[gi] = tx_data[8*gi +: 8];
      assign tx_ready[gi]   = w_tx_fire && (w_grant == IDX_W'(gi));
    end
  endgenerate

  assign w_tx_byte = w_tx_bytes[w_grant];
  assign w_in_chk  = r_run && (r_state == CHK_STAT);
  assign w_pop     = r_rx_valid && rx_ready;
  // A pop in the same cycle frees the holding register in time for this pass's read.
  assign w_rx_take = w_in_chk && acia_dout[ST_RXF] && (!r_rx_valid || rx_ready);
  assign w_tx_fire = w_in_chk && !w_rx_take && acia_dout[ST_TXE] && w_any;

  acia_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (tx_valid),
    .i_update (w_tx_fire),
    .o_grant  (w_grant),
    .o_any    (w_any)
  );

  // Bus outputs are registered alongside the state they belong to; r_run holds
  // the FSM in INIT_RST for the first cycle out of reset so the 8'h03 write is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= INIT_RST;
      r_run      <= 1'b0;
      r_cs       <= 1'b0;
      r_we       <= 1'b0;
      r_rs       <= RS_CTRL;
      r_din      <= '0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_rx_err   <= 1'b0;
      r_err_lat  <= 1'b0;
    end else begin
      r_run <= 1'b1;
      r_cs  <= 1'b0;
      r_we  <= 1'b0;
      r_rs  <= RS_CTRL;
      r_din <= '0;
      if (w_pop) r_rx_valid <= 1'b0;
      if (!r_run) begin
        r_state <= INIT_RST;
        r_cs    <= 1'b1;
        r_we    <= 1'b1;
        r_din   <= CTRL_MRST;
      end else begin
        case (r_state)
          INIT_RST: begin
            r_state <= INIT_CFG;
            r_cs    <= 1'b1;
            r_we    <= 1'b1;
            r_din   <= w_cfg_byte;
          end
          INIT_CFG: r_state <= IDLE;
          IDLE: begin
            if (w_irq_go) begin
              r_state <= RD_STAT;
              r_cs    <= 1'b1;
            end
          end
          RD_STAT: r_state <= CHK_STAT;
          CHK_STAT: begin
            if (w_rx_take) begin
              r_state   <= RD_DATA;
              r_cs      <= 1'b1;
              r_rs      <= RS_DATA;
              r_err_lat <= acia_dout[ST_ERR];
            end else if (w_tx_fire) begin
              r_state <= WR_DATA;
              r_cs    <= 1'b1;
              r_we    <= 1'b1;
              r_rs    <= RS_DATA;
              r_din   <= w_tx_byte;
            end else begin
              r_state <= IDLE;
            end
          end
          RD_DATA: r_state <= CAP_DATA;
          CAP_DATA: begin
            r_state    <= IDLE;
            r_rx_data  <= acia_dout;
            r_rx_err   <= r_err_lat;
            r_rx_valid <= 1'b1;
          end
          WR_DATA: r_state <= IDLE;
          default: r_state <= INIT_RST;
        endcase
      end
    end
  end

  assign acia_cs  = r_cs;
  assign acia_we  = r_we;
  assign acia_rs  = r_rs;
  assign acia_din = r_din;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  assign rx_err   = r_rx_err;

endmodule

// File: tb/tb_acia_arbiter.sv
// Directed bench for acia_arbiter with a behavioural ACIA and write/grant scoreboards.
module tb_acia_arbiter;

  localparam int         NR  = 4;
  localparam logic [7:0] CFG = 8'h15;
`ifdef ACIA_ARB_IRQ_EN
  localparam logic [7:0] CFG_EXP = 8'hB5;
`else
  localparam logic [7:0] CFG_EXP = 8'h15;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          acia_cs, acia_we, acia_rs;
  logic [7:0]    acia_din;
  logic [7:0]    acia_dout = 8'h00;
  logic          acia_irq;
  logic [NR-1:0] tx_valid, tx_ready;
  logic [8*NR-1:0] tx_data;
  logic          rx_valid, rx_err, rx_ready;
  logic [7:0]    rx_data;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_wr_q [$];
  int         exp_gnt_q [$];

  logic [7:0] st_bits = 8'h00;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] status_now;
  int rx_posted = 0;
  int data_reads = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  acia_arbiter #(.N_REQ(NR), .CTRL_INIT(CFG)) dut (
    .clk(clk), .rst(rst),
    .acia_cs(acia_cs), .acia_we(acia_we), .acia_rs(acia_rs), .acia_din(acia_din),
    .acia_dout(acia_dout), .acia_irq(acia_irq),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err), .rx_ready(rx_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ACIA model: RX full while posted bytes exceed data reads; read data appears after the strobe edge.
  assign status_now = {st_bits[7:1], rx_posted > data_reads};
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (acia_cs && !acia_we) begin
      if (acia_rs) begin
        acia_dout  <= rx_byte;
        data_reads <= data_reads + 1;
      end else begin
        acia_dout <= status_now;
      end
    end
  end

  // Scoreboard side: every ACIA write and every tx_ready pulse pops an expectation.
  always @(negedge clk) begin
    if (acia_cs && acia_we) begin
      check("wr_expected_present", 32'(exp_wr_q.size() != 0), 32'd1);
      if (exp_wr_q.size() != 0) check("wr_rs_din", 32'({acia_rs, acia_din}), 32'(exp_wr_q.pop_front()));
    end
    if (tx_ready != '0) begin
      check("gnt_expected_present", 32'(exp_gnt_q.size() != 0), 32'd1);
      if (exp_gnt_q.size() != 0) check("tx_ready_onehot", 32'(tx_ready), 32'd1 << exp_gnt_q.pop_front());
    end
  end

  task automatic wait_tx(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_ready != '0) begin ok = 1'b1; break; end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_rx(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rx_valid) begin ok = 1'b1; break; end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_reads(input string tag, input int target);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (data_reads >= target) begin ok = 1'b1; break; end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cs"}, 32'(acia_cs), 32'd0);
    check({tag, "_we"}, 32'(acia_we), 32'd0);
    check({tag, "_rs"}, 32'(acia_rs), 32'd0);
    check({tag, "_din"}, 32'(acia_din), 32'd0);
    check({tag, "_tx_ready"}, 32'(tx_ready), 32'd0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    check({tag, "_rx_err"}, 32'(rx_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    rst = 1'b1; tx_valid = '0; tx_data = '0; rx_ready = 1'b0; acia_irq = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    exp_wr_q.push_back({1'b0, 8'h03});
    exp_wr_q.push_back({1'b0, CFG_EXP});
    rst = 1'b0;
    @(negedge clk);
    check("c0_cs", 32'(acia_cs), 32'd1);
    check("c0_we", 32'(acia_we), 32'd1);
    check("c0_rs", 32'(acia_rs), 32'd0);
    check("c0_din", 32'(acia_din), 32'h03);
    @(negedge clk);
    check("c1_we", 32'(acia_we), 32'd1);
    check("c1_din", 32'(acia_din), 32'(CFG_EXP));
    @(negedge clk);
    check("c2_cs", 32'(acia_cs), 32'd0);
`ifdef ACIA_ARB_IRQ_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("irq_low_no_read", 32'(acia_cs), 32'd0);
    end
    acia_irq = 1'b1;
    @(negedge clk);
`else
    @(negedge clk);
`endif
    check("c3_cs", 32'(acia_cs), 32'd1);
    check("c3_we", 32'(acia_we), 32'd0);
    check("c3_rs", 32'(acia_rs), 32'd0);

    // Round robin with all requesters valid and TX always empty.
    st_bits = 8'h02;
    tx_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    exp_gnt_q.push_back(0); exp_wr_q.push_back({1'b1, 8'hA0});
    exp_gnt_q.push_back(1); exp_wr_q.push_back({1'b1, 8'hA1});
    exp_gnt_q.push_back(2); exp_wr_q.push_back({1'b1, 8'hA2});
    exp_gnt_q.push_back(3); exp_wr_q.push_back({1'b1, 8'hA3});
    exp_gnt_q.push_back(0); exp_wr_q.push_back({1'b1, 8'hA0});
    tx_valid = 4'b1111;
    prev = -1;
    for (int p = 0; p < 5; p++) begin
      wait_tx("rr_pulse_seen");
      if (prev >= 0) check("rr_pass_len", 32'(cyc - prev), 32'd4);
      prev = cyc;
    end
    @(posedge clk); #1 tx_valid = '0;
    @(negedge clk);
    check("rr_ready_one_cycle", 32'(tx_ready), 32'd0);
    check("rr_wr_din", 32'({acia_cs, acia_we, acia_rs, acia_din}), 32'({3'b111, 8'hA0}));

    // Single requester: grant 2, byte written the following cycle.
    @(negedge clk);
    tx_data = '0; tx_data[23:16] = 8'h41;
    exp_gnt_q.push_back(2); exp_wr_q.push_back({1'b1, 8'h41});
    tx_valid = 4'b0100;
    wait_tx("tx1_pulse_seen");
    check("tx1_ready", 32'(tx_ready), 32'b0100);
    @(posedge clk); #1 tx_valid = '0; tx_data = '1;
    @(negedge clk);
    check("tx1_we", 32'(acia_we), 32'd1);
    check("tx1_rs", 32'(acia_rs), 32'd1);
    check("tx1_din", 32'(acia_din), 32'h41);

    // RX with error bit, holding register not popped.
    @(negedge clk);
    tx_data = '0;
    rx_byte = 8'h5A; st_bits = 8'h12; rx_posted++;
    wait_reads("rx1_read_seen", 1);
    check("rx1_valid_not_early", 32'(rx_valid), 32'd0);
    @(negedge clk);
    check("rx1_valid", 32'(rx_valid), 32'd1);
    check("rx1_data", 32'(rx_data), 32'h5A);
    check("rx1_err", 32'(rx_err), 32'd1);
    tx_data[15:8] = 8'h77;
    exp_gnt_q.push_back(1); exp_wr_q.push_back({1'b1, 8'h77});
    tx_valid = 4'b0010;
    wait_tx("rx1_tx_pulse_seen");
    @(posedge clk); #1 tx_valid = '0;

    // Full holding register blocks further RX reads until a pop.
    rx_byte = 8'h66; st_bits = 8'h02; rx_posted++;
    repeat (20) @(negedge clk);
    check("rx_blocked_reads", 32'(data_reads), 32'd1);
    check("rx_blocked_data", 32'(rx_data), 32'h5A);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("rx_pop_falls", 32'(rx_valid), 32'd0);
    wait_rx("rx2_valid_seen");
    check("rx2_data", 32'(rx_data), 32'h66);
    check("rx2_err", 32'(rx_err), 32'd0);
    check("rx2_reads", 32'(data_reads), 32'd2);

    // Reset asserted during WR_DATA.
    @(negedge clk);
    tx_data[31:24] = 8'h99;
    exp_gnt_q.push_back(3); exp_wr_q.push_back({1'b1, 8'h99});
    tx_valid = 4'b1000;
    wait_tx("rst_tx_pulse_seen");
    @(posedge clk); #1 tx_valid = '0;
    @(negedge clk);
    check("rst_wr_din", 32'(acia_din), 32'h99);
    rst = 1'b1;
    exp_wr_q.push_back({1'b0, 8'h03});
    exp_wr_q.push_back({1'b0, CFG_EXP});
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    @(negedge clk);
    check("rerst_we", 32'(acia_we), 32'd1);
    check("rerst_din", 32'(acia_din), 32'h03);
    @(negedge clk);
    check("recfg_din", 32'(acia_din), 32'(CFG_EXP));

    repeat (10) @(negedge clk);
    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    check("gnt_queue_drained", 32'(exp_gnt_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
